// File: rtl/ps2_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_frame_rx_pkg
// Description : Shared constants, FSM state encoding and parity helper for the
//               PS/2 device-to-host frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_frame_rx_pkg;

    // Prefix bytes that are folded into flags instead of being reported
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Frame deframer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones
    function automatic logic ps2_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
        return (^data_byte) ^ parity_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : Synchronises the raw PS/2 clock and data pins, deglitches the
//               clock with a FILTER_LEN-deep agreement filter and produces a
//               one-cycle pulse on each filtered falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8    // must be at least 2
) (
    input  logic clk,
    input  logic rst,               // asynchronous, active-low
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_data_s,
    output logic o_fall
);

    logic [1:0]            r_clk_sync_q,  w_clk_sync_d;
    logic [1:0]            r_data_sync_q, w_data_sync_d;
    logic [FILTER_LEN-1:0] r_filt_sh_q,   w_filt_sh_d;
    logic                  r_filt_q,      w_filt_d;
    logic                  r_fall_q,      w_fall_d;

    // Next-state: synchroniser shift, filter history, hysteretic level and edge pulse
    always_comb begin
        w_clk_sync_d  = {r_clk_sync_q[0], i_ps2_clk};
        w_data_sync_d = {r_data_sync_q[0], i_ps2_data};
        w_filt_sh_d   = {r_filt_sh_q[FILTER_LEN-2:0], r_clk_sync_q[1]};
        w_filt_d      = r_filt_q;
        // Level only moves once every sample in the history agrees
        if (r_filt_sh_q == '0) begin
            w_filt_d = 1'b0;
        end else if (&r_filt_sh_q) begin
            w_filt_d = 1'b1;
        end
        w_fall_d      = r_filt_q & ~w_filt_d;
    end

    // Registers; idle PS/2 lines are high so everything resets to 1 except the pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync_q  <= 2'b11;
            r_data_sync_q <= 2'b11;
            r_filt_sh_q   <= '1;
            r_filt_q      <= 1'b1;
            r_fall_q      <= 1'b0;
        end else begin
            r_clk_sync_q  <= w_clk_sync_d;
            r_data_sync_q <= w_data_sync_d;
            r_filt_sh_q   <= w_filt_sh_d;
            r_filt_q      <= w_filt_d;
            r_fall_q      <= w_fall_d;
        end
    end

    assign o_data_s = r_data_sync_q[1];
    assign o_fall   = r_fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_frame_rx
// Description : PS/2 device-to-host receiver. Deframes 11-bit frames, checks
//               odd parity, stop bit and inter-bit timeout, folds E0/F0
//               prefixes into flags and pulses code_valid once per key event.
//               The release flag port is named release_key because "release"
//               is a reserved word.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_frame_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       release_key,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int                 c_tmo_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    logic w_data_s;
    logic w_fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_data_s   (w_data_s),
        .o_fall     (w_fall)
    );

    ps2_state_e         r_state_q,      w_state_d;
    logic [7:0]         r_shift_q,      w_shift_d;
    logic [2:0]         r_bit_cnt_q,    w_bit_cnt_d;
    logic               r_parity_q,     w_parity_d;
    logic [c_tmo_w-1:0] r_tmo_q,        w_tmo_d;
    logic               r_ext_pend_q,   w_ext_pend_d;
    logic               r_brk_pend_q,   w_brk_pend_d;
    logic [7:0]         r_scancode_q,   w_scancode_d;
    logic               r_ext_q,        w_ext_d;
    logic               r_rel_q,        w_rel_d;
    logic               r_code_valid_q, w_code_valid_d;
    logic               r_parity_err_q, w_parity_err_d;
    logic               r_frame_err_q,  w_frame_err_d;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state, datapath and output pulse decode; a fall always takes priority over timeout
    always_comb begin
        w_state_d      = r_state_q;
        w_shift_d      = r_shift_q;
        w_bit_cnt_d    = r_bit_cnt_q;
        w_parity_d     = r_parity_q;
        w_ext_pend_d   = r_ext_pend_q;
        w_brk_pend_d   = r_brk_pend_q;
        w_scancode_d   = r_scancode_q;
        w_ext_d        = r_ext_q;
        w_rel_d        = r_rel_q;
        w_code_valid_d = 1'b0;
        w_parity_err_d = 1'b0;
        w_frame_err_d  = 1'b0;

        if ((r_state_q == IDLE) || w_fall) begin
            w_tmo_d = '0;
        end else begin
            w_tmo_d = r_tmo_q + c_tmo_w'(1);
        end

        if (w_fall) begin
            case (r_state_q)
                IDLE: begin
                    // A high bit while idle is line noise, not a start bit
                    if (!w_data_s) begin
                        w_state_d   = DATA;
                        w_bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    w_shift_d = {w_data_s, r_shift_q[7:1]};
                    if (r_bit_cnt_q == 3'd7) begin
                        w_state_d = PARITY;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    w_parity_d = w_data_s;
                    w_state_d  = STOP;
                end
                STOP: begin
                    w_state_d = IDLE;
                    if (!w_data_s) begin
                        w_frame_err_d = 1'b1;
                        w_ext_pend_d  = 1'b0;
                        w_brk_pend_d  = 1'b0;
                    end else if (!ps2_parity_ok(r_shift_q, r_parity_q)) begin
                        w_parity_err_d = 1'b1;
                        w_ext_pend_d   = 1'b0;
                        w_brk_pend_d   = 1'b0;
                    end else if (r_shift_q == PS2_PREFIX_EXT) begin
                        w_ext_pend_d = 1'b1;
                    end else if (r_shift_q == PS2_PREFIX_BRK) begin
                        w_brk_pend_d = 1'b1;
                    end else begin
                        w_scancode_d   = r_shift_q;
                        w_ext_d        = r_ext_pend_q;
                        w_rel_d        = r_brk_pend_q;
                        w_code_valid_d = 1'b1;
                        w_ext_pend_d   = 1'b0;
                        w_brk_pend_d   = 1'b0;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end else if ((r_state_q != IDLE) && (r_tmo_q == c_tmo_last)) begin
            // Device stalled mid-frame: abandon it and forget any pending prefix
            w_state_d     = IDLE;
            w_frame_err_d = 1'b1;
            w_ext_pend_d  = 1'b0;
            w_brk_pend_d  = 1'b0;
        end
    end

    // Datapath and registered output flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift_q      <= '0;
            r_bit_cnt_q    <= '0;
            r_parity_q     <= 1'b0;
            r_tmo_q        <= '0;
            r_ext_pend_q   <= 1'b0;
            r_brk_pend_q   <= 1'b0;
            r_scancode_q   <= '0;
            r_ext_q        <= 1'b0;
            r_rel_q        <= 1'b0;
            r_code_valid_q <= 1'b0;
            r_parity_err_q <= 1'b0;
            r_frame_err_q  <= 1'b0;
        end else begin
            r_shift_q      <= w_shift_d;
            r_bit_cnt_q    <= w_bit_cnt_d;
            r_parity_q     <= w_parity_d;
            r_tmo_q        <= w_tmo_d;
            r_ext_pend_q   <= w_ext_pend_d;
            r_brk_pend_q   <= w_brk_pend_d;
            r_scancode_q   <= w_scancode_d;
            r_ext_q        <= w_ext_d;
            r_rel_q        <= w_rel_d;
            r_code_valid_q <= w_code_valid_d;
            r_parity_err_q <= w_parity_err_d;
            r_frame_err_q  <= w_frame_err_d;
        end
    end

    assign scancode    = r_scancode_q;
    assign extended    = r_ext_q;
    assign release_key = r_rel_q;
    assign code_valid  = r_code_valid_q;
    assign parity_err  = r_parity_err_q;
    assign frame_err   = r_frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_frame_rx
// Description : Scoreboard bench for ps2_frame_rx. Stimulus pushes expected
//               events; a monitor pops and compares on every output pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_frame_rx;

    localparam int TMO  = 2000;
    localparam int HALF = 40;

    localparam int K_VALID = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       extended;
    logic       release_key;
    logic       code_valid;
    logic       parity_err;
    logic       frame_err;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int last_fall = 0;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        int         lo;
        int         hi;
    } exp_t;

    exp_t q[$];

    ps2_frame_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scancode    (scancode),
        .extended    (extended),
        .release_key (release_key),
        .code_valid  (code_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] c, input logic e, input logic r,
                             input int lo, input int hi);
        exp_t x;
        x.kind = kind; x.code = c; x.ext = e; x.rel = r; x.lo = lo; x.hi = hi;
        q.push_back(x);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives the first nbits bits of a frame; glitch_bit selects a bit that gets a short clock glitch
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input logic stop,
                             input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            if (i == glitch_bit) begin
                wait_cyc(10);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 13);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b1, 11, -1);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    // Monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin : mon
        int   k;
        exp_t e;
        if (rst_n && (code_valid || parity_err || frame_err)) begin
            total++;
            k = code_valid ? K_VALID : (parity_err ? K_PERR : K_FERR);
            if ((int'(code_valid) + int'(parity_err) + int'(frame_err)) != 1) begin
                bad++;
                $display("FAIL onehot: valid=%0b perr=%0b ferr=%0b", code_valid, parity_err, frame_err);
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: kind=%0d code=%0h at cyc %0d, none expected", k, scancode, cyc);
            end else begin
                e = q.pop_front();
                if (k != e.kind || scancode != e.code || extended != e.ext || release_key != e.rel ||
                    (e.lo >= 0 && (cyc < e.lo || cyc > e.hi))) begin
                    bad++;
                    $display("FAIL event: got kind=%0d code=%0h ext=%0b rel=%0b cyc=%0d, expected kind=%0d code=%0h ext=%0b rel=%0b cyc %0d..%0d",
                             k, scancode, extended, release_key, cyc, e.kind, e.code, e.ext, e.rel, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        wait_cyc(5);
        check_val("rst_scancode", int'(scancode), 0);
        check_val("rst_extended", int'(extended), 0);
        check_val("rst_release", int'(release_key), 0);
        check_val("rst_code_valid", int'(code_valid), 0);
        check_val("rst_parity_err", int'(parity_err), 0);
        check_val("rst_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        wait_cyc(20);

        // Up-arrow make
        expect_ev(K_VALID, 8'h75, 1'b1, 1'b0, -1, -1);
        send_frame(8'hE0);
        send_frame(8'h75);

        // Up-arrow break, then plain key
        expect_ev(K_VALID, 8'h75, 1'b1, 1'b1, -1, -1);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        expect_ev(K_VALID, 8'h1C, 1'b0, 1'b0, -1, -1);
        send_frame(8'h1C);

        // Parity error holds previous code; a good 72 follows
        expect_ev(K_PERR, 8'h1C, 1'b0, 1'b0, -1, -1);
        send_bits(8'h72, 1'b1, 1'b1, 11, -1);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
        expect_ev(K_VALID, 8'h72, 1'b0, 1'b0, -1, -1);
        send_frame(8'h72);

        // Timeout after start plus 4 data bits
        send_bits(8'hA5, 1'b0, 1'b1, 5, -1);
        expect_ev(K_FERR, 8'h72, 1'b0, 1'b0, last_fall + TMO - 2, last_fall + TMO + 30);
        ps2_data = 1'b1;
        wait_cyc(2400);
        expect_ev(K_VALID, 8'h29, 1'b0, 1'b0, -1, -1);
        send_frame(8'h29);

        // Clock glitch mid-frame must not shift an extra bit
        expect_ev(K_VALID, 8'h5A, 1'b0, 1'b0, -1, -1);
        send_bits(8'h5A, 1'b0, 1'b1, 11, 4);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);

        // Bad stop bit
        expect_ev(K_FERR, 8'h5A, 1'b0, 1'b0, -1, -1);
        send_bits(8'h33, 1'b0, 1'b0, 11, -1);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);

        // F0 then E0 sets both flags
        expect_ev(K_VALID, 8'h14, 1'b1, 1'b1, -1, -1);
        send_frame(8'hF0);
        send_frame(8'hE0);
        send_frame(8'h14);

        // An error discards a pending prefix
        send_frame(8'hE0);
        expect_ev(K_PERR, 8'h14, 1'b1, 1'b1, -1, -1);
        send_bits(8'h33, 1'b1, 1'b1, 11, -1);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
        expect_ev(K_VALID, 8'h6B, 1'b0, 1'b0, -1, -1);
        send_frame(8'h6B);

        // Reset after the 5th data bit of F0
        send_bits(8'hF0, 1'b0, 1'b1, 6, -1);
        wait_cyc(5);
        rst_n = 1'b0;
        wait_cyc(3);
        check_val("midrst_scancode", int'(scancode), 0);
        check_val("midrst_extended", int'(extended), 0);
        check_val("midrst_release", int'(release_key), 0);
        ps2_data = 1'b1;
        rst_n    = 1'b1;
        wait_cyc(40);
        expect_ev(K_VALID, 8'h75, 1'b0, 1'b0, -1, -1);
        send_frame(8'h75);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 3000 && q.size() != 0; i++) wait_cyc(1);
        wait_cyc(50);
        check_val("events_outstanding", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
